priority_cluster_extract: RTL and testbench
===========================================

Name: priority_cluster_extract

Overview:
- Parametrised successor to the single-winner 768-pad priority encoder in the cluster packer.
- Snapshots one frame of pad valid flags and counts, aligned to the frame clock.
- Runs a pipelined binary priority tree repeatedly over the snapshot; each pass clears the previous winner, so up to MXCLUSTERS clusters are extracted per frame, lowest address first.
- Sits between cluster finding and the packer output formatter.

Parameters:
MXPADS, 768, number of pads; the tree is padded with zeros to 2^MXKEYBITS.
MXKEYBITS, 10, address width; must satisfy 2^MXKEYBITS >= MXPADS.
MXCNTBITS, 3, per-pad count width.
MXCLUSTERS, 2, maximum clusters extracted per frame.
REG_EVERY, 10, tree levels between pipeline registers; LAT = ceil(MXKEYBITS/REG_EVERY).
FRAME_RATIO, 8, fast clocks per frame_clock period; must satisfy 3 + 2*MXCLUSTERS*LAT <= FRAME_RATIO.

Ports:
clock  in  1  fast clock (160 MHz)
reset  in  1  synchronous, active-high
frame_clock  in  1  slow frame clock, sampled on clock
pass_in  in  3  pass tag, captured with the snapshot
vpfs_in  in  MXPADS  pad valid flags
cnts_in  in  MXPADS*MXCNTBITS  pad counts, pad i at bits [i*MXCNTBITS +: MXCNTBITS]
cluster_valid  out  1  one-cycle pulse per extracted cluster
adr  out  MXKEYBITS  winning pad address; all ones when cluster_valid=0
cnt  out  MXCNTBITS  winning count; zero when cluster_valid=0
cluster_idx  out  max(1,clog2(MXCLUSTERS))  0-based index of the cluster within the frame
pass_out  out  3  captured pass tag, valid with cluster_valid and frame_done
frame_done  out  1  one-cycle pulse ending a frame's extraction
overflow  out  1  qualified by frame_done; set when more valid pads remained than MXCLUSTERS
ovf_count  out  16  overflow frame counter (optional feature)

Behaviour:
- Reset:
  - Frame-clock sampler cleared, FSM to IDLE, working vector cleared.
  - All outputs deasserted; adr all ones, cnt 0, cluster_idx 0, pass_out 0, ovf_count 0.
- Strobe:
  - 3-bit shift register fs samples frame_clock each cycle.
  - strobe = (fs[2:1] == 2'b01).
  - In the strobe cycle T: work_vpf <= vpfs_in, work_cnt <= cnts_in, pass <= pass_in, k <= 0, FSM -> SEARCH.
- Tree:
  - Level l halves the candidate set; the even (lower) candidate wins if valid; key bit l-1 is appended as MSB-side growth.
  - Pipeline registers after every REG_EVERY levels and after the final level; total LAT cycles.
- SEARCH:
  - Each pass starts with the work vector stable.
  - The winner is available LAT cycles later and registered to the outputs one cycle after that.
  - Pass period P = LAT+1.
  - Cluster k is output in cycle T+2+LAT+k*P (defaults: T+3, T+5).
  - In the output cycle, the winner bit of work_vpf is cleared and k increments.
- Pass with no valid pad (k < MXCLUSTERS):
  - No cluster_valid.
  - frame_done=1 and overflow=0 in cycle T+2+LAT+k*P.
  - FSM -> IDLE.
- k reaches MXCLUSTERS:
  - One further probe pass runs and produces no cluster output.
  - frame_done is asserted in cycle T+2+LAT+MXCLUSTERS*P; overflow = probe found bit.
  - FSM -> IDLE.
- Empty snapshot: frame_done at T+2+LAT with no clusters.
- Strobe during SEARCH:
  - Abort the current frame; no frame_done for the aborted frame.
  - Recapture immediately; cluster_idx restarts at 0.
- Reset mid-SEARCH: outputs return to reset values the next cycle; no pulses are emitted.
- Outputs are registered; cluster_valid and frame_done never exceed one cycle each.

Optional Feature:
- PRIORITY_OVF_COUNTER_EN defined:
  - ovf_count increments on each frame_done with overflow=1.
  - Saturates at 0xFFFF; cleared only by reset.
- Not defined: ovf_count is tied to 0 and no counter logic is built.

Test Plan:
- Vectors 3 (cnt 5) and 700 (cnt 2) with strobe at T -> cluster_valid at T+3 (adr 3, cnt 5, idx 0) and T+5 (adr 700, cnt 2, idx 1); probe -> frame_done at T+7, overflow 0.
- Vectors 0, 1 and 767 -> clusters adr 0 then adr 1; frame_done at T+7 with overflow=1; ovf_count=1 when PRIORITY_OVF_COUNTER_EN is defined.
- All vpfs zero -> no cluster_valid; frame_done at T+3, overflow 0; adr stays 0x3FF, cnt 0.
- frame_clock period shortened so a strobe arrives at T+4 -> T's second cluster suppressed, no frame_done for T; new frame clusters at T+7 onward with idx 0.
- Reset asserted at T+4 with a search in flight -> all outputs at reset values from T+5; no pulses until the next strobe.
- Overflow frame repeated 65540 times with the macro defined -> ovf_count holds at 0xFFFF.

Source files
------------

// File: rtl/priority_cluster_extract.sv
// Per-frame snapshot of pad flags; extracts up to MXCLUSTERS lowest-address clusters through a pipelined priority tree.
// First cluster 2+LAT cycles after the frame strobe, then every LAT+1; no backpressure. PRIORITY_OVF_COUNTER_EN enables ovf_count.
module priority_cluster_extract #(
  parameter int  MXPADS      = 768,
  parameter int  MXKEYBITS   = 10,
  parameter int  MXCNTBITS   = 3,
  parameter int  MXCLUSTERS  = 2,
  parameter int  REG_EVERY   = 10,
  parameter int  FRAME_RATIO = 8,
  localparam int IDXW        = (MXCLUSTERS > 1) ? $clog2(MXCLUSTERS) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        frame_clock,
  input  logic [2:0]                  pass_in,
  input  logic [MXPADS-1:0]           vpfs_in,
  input  logic [MXPADS*MXCNTBITS-1:0] cnts_in,
  output logic                        cluster_valid,
  output logic [MXKEYBITS-1:0]        adr,
  output logic [MXCNTBITS-1:0]        cnt,
  output logic [IDXW-1:0]             cluster_idx,
  output logic [2:0]                  pass_out,
  output logic                        frame_done,
  output logic                        overflow,
  output logic [15:0]                 ovf_count
);

  localparam int NPAD = 1 << MXKEYBITS;
  localparam int LAT  = (MXKEYBITS + REG_EVERY - 1) / REG_EVERY;
  localparam int KW   = $clog2(MXCLUSTERS + 1);
  // a pass never outlasts a frame, so the phase counter is sized by the frame length
  localparam int PHW  = $clog2(FRAME_RATIO);

  typedef enum logic {IDLE, SEARCH} state_t;
  state_t state, state_nxt;

  logic [2:0]                  fs;
  logic                        strobe;
  logic [MXPADS-1:0]           work_vpf;
  logic [MXPADS*MXCNTBITS-1:0] work_cnt;
  logic [2:0]                  pass;
  logic [KW-1:0]               k;
  logic [PHW-1:0]              ph;
  logic                        decide, emit, done;
  logic                        win_vld;
  logic [MXKEYBITS-1:0]        win_key;
  logic [MXCNTBITS-1:0]        win_cnt;

  assign strobe   = (fs[2:1] == 2'b01);
  assign decide   = (state == SEARCH) && (ph == PHW'(LAT));
  assign pass_out = pass;

  genvar l, j;
  for (l = 0; l <= MXKEYBITS; l++) begin : g_lvl
    localparam int N = NPAD >> l;
    logic [N-1:0]         v_o;
    logic [MXKEYBITS-1:0] key_o [N];
    logic [MXCNTBITS-1:0] cnt_o [N];
    if (l == 0) begin : g_leaf
      for (j = 0; j < N; j++) begin : g_pad
        if (j < MXPADS) begin : g_real
          assign v_o[j]   = work_vpf[j];
          assign cnt_o[j] = work_cnt[j*MXCNTBITS +: MXCNTBITS];
        end else begin : g_zero
          assign v_o[j]   = 1'b0;
          assign cnt_o[j] = '0;
        end
        assign key_o[j] = '0;
      end
    end else begin : g_node
      logic [N-1:0]         v_c;
      logic [MXKEYBITS-1:0] key_c [N];
      logic [MXCNTBITS-1:0] cnt_c [N];
      for (j = 0; j < N; j++) begin : g_pair
        logic lo;
        // lower address wins whenever it is valid
        assign lo       = g_lvl[l-1].v_o[2*j];
        assign v_c[j]   = lo | g_lvl[l-1].v_o[2*j+1];
        assign key_c[j] = lo ? g_lvl[l-1].key_o[2*j]
                             : (g_lvl[l-1].key_o[2*j+1] | (MXKEYBITS'(1) << (l-1)));
        assign cnt_c[j] = lo ? g_lvl[l-1].cnt_o[2*j] : g_lvl[l-1].cnt_o[2*j+1];
      end
      if ((l % REG_EVERY == 0) || (l == MXKEYBITS)) begin : g_reg
        always_ff @(posedge clock) begin
          v_o   <= v_c;
          key_o <= key_c;
          cnt_o <= cnt_c;
        end
      end else begin : g_comb
        assign v_o   = v_c;
        assign key_o = key_c;
        assign cnt_o = cnt_c;
      end
    end
  end

  assign win_vld = g_lvl[MXKEYBITS].v_o[0];
  assign win_key = g_lvl[MXKEYBITS].key_o[0];
  assign win_cnt = g_lvl[MXKEYBITS].cnt_o[0];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // a new strobe always wins, aborting whatever pass is in flight
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    done      = 1'b0;
    if (strobe) begin
      state_nxt = SEARCH;
    end else if (decide) begin
      if (win_vld && (k < KW'(MXCLUSTERS))) begin
        emit = 1'b1;
      end else begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fs            <= '0;
      work_vpf      <= '0;
      work_cnt      <= '0;
      pass          <= '0;
      k             <= '0;
      ph            <= '0;
      cluster_valid <= 1'b0;
      adr           <= '1;
      cnt           <= '0;
      cluster_idx   <= '0;
      frame_done    <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      fs            <= {fs[1:0], frame_clock};
      cluster_valid <= emit;
      frame_done    <= done;
      overflow      <= done & win_vld;
      adr           <= emit ? win_key : '1;
      cnt           <= emit ? win_cnt : '0;
      if (strobe) begin
        work_vpf    <= vpfs_in;
        work_cnt    <= cnts_in;
        pass        <= pass_in;
        k           <= '0;
        ph          <= '0;
        cluster_idx <= '0;
      end else if (state == SEARCH) begin
        ph <= decide ? '0 : ph + PHW'(1);
        if (emit) begin
          work_vpf[win_key] <= 1'b0;
          k                 <= k + KW'(1);
          cluster_idx       <= k[IDXW-1:0];
        end
      end
    end
  end

`ifdef PRIORITY_OVF_COUNTER_EN
  logic [15:0] ovf_q;
  always_ff @(posedge clock) begin
    if (reset)                                           ovf_q <= '0;
    else if (done && win_vld && (ovf_q != 16'hFFFF))     ovf_q <= ovf_q + 16'd1;
  end
  assign ovf_count = ovf_q;
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_priority_cluster_extract.sv
// Directed bench for priority_cluster_extract: normal, overflow, empty, aborted and reset-interrupted frames.
module tb_priority_cluster_extract;
  localparam int MXPADS    = 768;
  localparam int MXKEYBITS = 10;
  localparam int MXCNTBITS = 3;
`ifdef PRIORITY_OVF_COUNTER_EN
  localparam int OVF1 = 1;
`else
  localparam int OVF1 = 0;
`endif

  logic                        clock = 1'b0;
  logic                        reset = 1'b1;
  logic                        frame_clock = 1'b0;
  logic [2:0]                  pass_in = '0;
  logic [MXPADS-1:0]           vpfs_in = '0;
  logic [MXPADS*MXCNTBITS-1:0] cnts_in = '0;
  logic                        cluster_valid;
  logic [MXKEYBITS-1:0]        adr;
  logic [MXCNTBITS-1:0]        cnt;
  logic [0:0]                  cluster_idx;
  logic [2:0]                  pass_out;
  logic                        frame_done;
  logic                        overflow;
  logic [15:0]                 ovf_count;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  priority_cluster_extract dut (
    .clock        (clock),
    .reset        (reset),
    .frame_clock  (frame_clock),
    .pass_in      (pass_in),
    .vpfs_in      (vpfs_in),
    .cnts_in      (cnts_in),
    .cluster_valid(cluster_valid),
    .adr          (adr),
    .cnt          (cnt),
    .cluster_idx  (cluster_idx),
    .pass_out     (pass_out),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .ovf_count    (ovf_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one cycle, sample 1 ns after the edge, compare against the hand schedule
  task automatic step(input string tag, input logic ecv, input logic [9:0] ea, input logic [2:0] ec,
                      input logic ei, input logic efd, input logic eov, input logic [2:0] ep);
    @(posedge clock);
    #1;
    chk({tag, ".cv"},  {31'd0, cluster_valid}, {31'd0, ecv});
    chk({tag, ".fd"},  {31'd0, frame_done},    {31'd0, efd});
    chk({tag, ".adr"}, {22'd0, adr},           {22'd0, ea});
    chk({tag, ".cnt"}, {29'd0, cnt},           {29'd0, ec});
    if (ecv)        chk({tag, ".idx"}, {31'd0, cluster_idx}, {31'd0, ei});
    if (efd)        chk({tag, ".ovf"}, {31'd0, overflow},    {31'd0, eov});
    if (ecv || efd) chk({tag, ".pass"}, {29'd0, pass_out},   {29'd0, ep});
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 10'h3FF, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic clear_pads();
    vpfs_in = '0;
    cnts_in = '0;
  endtask

  task automatic set_pad(input int i, input logic [2:0] c);
    vpfs_in[i] = 1'b1;
    cnts_in[i*MXCNTBITS +: MXCNTBITS] = c;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".cv"},   {31'd0, cluster_valid}, 32'd0);
    chk({tag, ".adr"},  {22'd0, adr},           32'h3FF);
    chk({tag, ".cnt"},  {29'd0, cnt},           32'd0);
    chk({tag, ".idx"},  {31'd0, cluster_idx},   32'd0);
    chk({tag, ".pass"}, {29'd0, pass_out},      32'd0);
    chk({tag, ".fd"},   {31'd0, frame_done},    32'd0);
    chk({tag, ".ovf"},  {31'd0, overflow},      32'd0);
    chk({tag, ".ovfc"}, {16'd0, ovf_count},     32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk_reset_vals("rst");
    reset = 1'b0;
    idle("rst.rel");

    // frame 1: pads 3 and 700; frame_clock rises in cycle P, strobe T = P+2
    clear_pads(); set_pad(3, 3'd5); set_pad(700, 3'd2); pass_in = 3'd5; frame_clock = 1'b1;
    idle("f1.p1"); frame_clock = 1'b0;
    idle("f1.t0");
    idle("f1.t1"); clear_pads(); pass_in = 3'd0;
    idle("f1.t2");
    step("f1.c0", 1'b1, 10'd3, 3'd5, 1'b0, 1'b0, 1'b0, 3'd5);
    idle("f1.t4");
    step("f1.c1", 1'b1, 10'd700, 3'd2, 1'b1, 1'b0, 1'b0, 3'd5);
    idle("f1.t6");
    step("f1.done", 1'b0, 10'h3FF, 3'd0, 1'b0, 1'b1, 1'b0, 3'd5);
    idle("f1.t8");

    // frame 2: three valid pads, third left over
    clear_pads(); set_pad(0, 3'd1); set_pad(1, 3'd6); set_pad(767, 3'd7); pass_in = 3'd2; frame_clock = 1'b1;
    idle("f2.p1"); frame_clock = 1'b0;
    idle("f2.t0");
    idle("f2.t1");
    idle("f2.t2");
    step("f2.c0", 1'b1, 10'd0, 3'd1, 1'b0, 1'b0, 1'b0, 3'd2);
    idle("f2.t4");
    step("f2.c1", 1'b1, 10'd1, 3'd6, 1'b1, 1'b0, 1'b0, 3'd2);
    idle("f2.t6");
    step("f2.done", 1'b0, 10'h3FF, 3'd0, 1'b0, 1'b1, 1'b1, 3'd2);
    chk("f2.ovfcnt", {16'd0, ovf_count}, OVF1);
    idle("f2.t8");

    // frame 3: empty snapshot
    clear_pads(); pass_in = 3'd7; frame_clock = 1'b1;
    idle("f3.p1"); frame_clock = 1'b0;
    idle("f3.t0");
    idle("f3.t1");
    idle("f3.t2");
    step("f3.done", 1'b0, 10'h3FF, 3'd0, 1'b0, 1'b1, 1'b0, 3'd7);
    idle("f3.t4");
    chk("f3.ovfcnt", {16'd0, ovf_count}, OVF1);

    // frame 4: second strobe at T+4 aborts frame A and restarts with frame B
    clear_pads(); set_pad(10, 3'd3); set_pad(20, 3'd4); pass_in = 3'd1; frame_clock = 1'b1;
    idle("f4.p1"); frame_clock = 1'b0;
    idle("f4.t0");
    idle("f4.t1");
    idle("f4.t2");
    clear_pads(); set_pad(30, 3'd1); set_pad(40, 3'd2); pass_in = 3'd6; frame_clock = 1'b1;
    step("f4.a0", 1'b1, 10'd10, 3'd3, 1'b0, 1'b0, 1'b0, 3'd1);
    frame_clock = 1'b0;
    idle("f4.t4");
    idle("f4.t5");
    idle("f4.t6");
    step("f4.b0", 1'b1, 10'd30, 3'd1, 1'b0, 1'b0, 1'b0, 3'd6);
    idle("f4.t8");
    step("f4.b1", 1'b1, 10'd40, 3'd2, 1'b1, 1'b0, 1'b0, 3'd6);
    idle("f4.t10");
    step("f4.done", 1'b0, 10'h3FF, 3'd0, 1'b0, 1'b1, 1'b0, 3'd6);
    idle("f4.t12");

    // frame 5: reset held through cycle T+4 with the second pass in flight
    clear_pads(); set_pad(50, 3'd5); set_pad(60, 3'd6); pass_in = 3'd4; frame_clock = 1'b1;
    idle("f5.p1"); frame_clock = 1'b0;
    idle("f5.t0");
    idle("f5.t1");
    idle("f5.t2");
    step("f5.c0", 1'b1, 10'd50, 3'd5, 1'b0, 1'b0, 1'b0, 3'd4);
    idle("f5.t4"); reset = 1'b1;
    @(posedge clock);
    #1;
    chk_reset_vals("f5.rst");
    reset = 1'b0;
    for (int i = 0; i < 6; i++) idle("f5.quiet");

    // frame 6: recovery after reset, single pad at the top address
    clear_pads(); set_pad(767, 3'd7); pass_in = 3'd3; frame_clock = 1'b1;
    idle("f6.p1"); frame_clock = 1'b0;
    idle("f6.t0");
    idle("f6.t1");
    idle("f6.t2");
    step("f6.c0", 1'b1, 10'd767, 3'd7, 1'b0, 1'b0, 1'b0, 3'd3);
    idle("f6.t4");
    step("f6.done", 1'b0, 10'h3FF, 3'd0, 1'b0, 1'b1, 1'b0, 3'd3);
    idle("f6.t6");
    chk("f6.ovfcnt", {16'd0, ovf_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
